writeback_commit: RTL and testbench

- In-order writeback/commit end of the tagged issue path.
- Functional units (ALU0, ALU1, load unit) return results tagged with the tag the TaggingSystem allocated at issue.
- This block buffers results by tag and retires them strictly in tag order, one per cycle, onto the RegisterFile Write_* port and the Forward1 bypass.
- It also tracks outstanding tags and raises a stall when every tag is in flight.

---
 rtl/commit_pkg.sv | 23 ++
 rtl/commit_slot_array.sv | 84 ++++++++
 rtl/writeback_commit.sv | 180 ++++++++++++++++++
 tb/tb_writeback_commit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared constants and types for the in-order writeback/commit block.
package commit_pkg;

  // Default field widths of one commit slot.
  localparam int DATA_W    = 16;
  localparam int REGADDR_W = 4;
  localparam int TAG_W     = 6;

  // Completion port indices; a lower index wins a same-tag collision.
  localparam int NUM_PORTS = 3;
  localparam int PORT_ALU0 = 0;
  localparam int PORT_ALU1 = 1;
  localparam int PORT_MEM  = 2;

  // Layout of one slot at the default widths.
  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [REGADDR_W-1:0] regaddr;
    logic [DATA_W-1:0]    data;
  } commit_slot_t;

endpackage

// File: rtl/commit_slot_array.sv
// Tag-indexed result buffer: three write ports, one combinational read
// port and a single valid-clear port used by retirement.
module commit_slot_array
  import commit_pkg::*;
#(
  parameter int DATA_W    = commit_pkg::DATA_W,
  parameter int REGADDR_W = commit_pkg::REGADDR_W,
  parameter int TAG_W     = commit_pkg::TAG_W,
  parameter int NUM_WR    = NUM_PORTS
) (
  input  logic                              clk,
  input  logic                              clk_en_i,
  input  logic                              sync_rst_i,
  input  logic [NUM_WR-1:0]                 wr_en_i,
  input  logic [NUM_WR-1:0][TAG_W-1:0]      wr_tag_i,
  input  logic [NUM_WR-1:0]                 wr_regwrite_i,
  input  logic [NUM_WR-1:0][REGADDR_W-1:0]  wr_regaddr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data_i,
  input  logic                              clr_en_i,
  input  logic [TAG_W-1:0]                  clr_tag_i,
  input  logic [TAG_W-1:0]                  rd_tag_i,
  output logic                              rd_valid_o,
  output logic                              rd_regwrite_o,
  output logic [REGADDR_W-1:0]              rd_regaddr_o,
  output logic [DATA_W-1:0]                 rd_data_o,
  output logic [(1<<TAG_W)-1:0]             valid_o
);

  localparam int SLOTS = 1 << TAG_W;
  localparam int PAY_W = 1 + REGADDR_W + DATA_W;

  // Payload carries no reset; only the valid bits need clearing.
  logic [PAY_W-1:0] payload_q [SLOTS];
  logic [SLOTS-1:0] valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_valid
      logic slot_valid_q;
      logic set_hit;

      // Does any write port target this slot this cycle?
      always_comb begin
        set_hit = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en_i[p] && (wr_tag_i[p] == TAG_W'(gi))) set_hit = 1'b1;
        end
      end

      // Per-slot valid bit: set by capture, cleared by retirement.
      always_ff @(posedge clk) begin
        if (sync_rst_i) begin
          slot_valid_q <= 1'b0;
        end else if (clk_en_i) begin
          if (set_hit) begin
            slot_valid_q <= 1'b1;
          end else if (clr_en_i && (clr_tag_i == TAG_W'(gi))) begin
            slot_valid_q <= 1'b0;
          end
        end
      end

      assign valid_vec[gi] = slot_valid_q;
    end
  endgenerate

  // Payload capture; the caller guarantees distinct tags across ports.
  always_ff @(posedge clk) begin
    if (clk_en_i) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en_i[p]) begin
          payload_q[wr_tag_i[p]] <= {wr_regwrite_i[p], wr_regaddr_i[p], wr_data_i[p]};
        end
      end
    end
  end

  assign valid_o       = valid_vec;
  assign rd_valid_o    = valid_vec[rd_tag_i];
  assign rd_regwrite_o = payload_q[rd_tag_i][PAY_W-1];
  assign rd_regaddr_o  = payload_q[rd_tag_i][DATA_W +: REGADDR_W];
  assign rd_data_o     = payload_q[rd_tag_i][DATA_W-1:0];

endmodule

// File: rtl/writeback_commit.sv
// In-order writeback/commit: buffers tagged completions and retires them
// one per cycle in tag order onto the register-file write and bypass path.
module writeback_commit
  import commit_pkg::*;
#(
  parameter int DATABITWIDTH    = DATA_W,
  parameter int REGADDRBITWIDTH = REGADDR_W,
  parameter int TAGBITWIDTH     = TAG_W
) (
  input  logic                       clk,
  input  logic                       clk_en,
  input  logic                       sync_rst,
  input  logic                       TagREQ,
  input  logic                       ALU0_Valid,
  input  logic [TAGBITWIDTH-1:0]     ALU0_Tag,
  input  logic                       ALU0_RegWriteEn,
  input  logic [REGADDRBITWIDTH-1:0] ALU0_RegAddr,
  input  logic [DATABITWIDTH-1:0]    ALU0_Data,
  input  logic                       ALU1_Valid,
  input  logic [TAGBITWIDTH-1:0]     ALU1_Tag,
  input  logic                       ALU1_RegWriteEn,
  input  logic [REGADDRBITWIDTH-1:0] ALU1_RegAddr,
  input  logic [DATABITWIDTH-1:0]    ALU1_Data,
  input  logic                       Mem_Valid,
  input  logic [TAGBITWIDTH-1:0]     Mem_Tag,
  input  logic                       Mem_RegWriteEn,
  input  logic [REGADDRBITWIDTH-1:0] Mem_RegAddr,
  input  logic [DATABITWIDTH-1:0]    Mem_Data,
  output logic                       Write_En,
  output logic [REGADDRBITWIDTH-1:0] Write_Address,
  output logic [DATABITWIDTH-1:0]    Write_Data,
  output logic                       Forward1Valid,
  output logic [REGADDRBITWIDTH-1:0] Forward1RegAddr,
  output logic [DATABITWIDTH-1:0]    Forward1Data,
  output logic [TAGBITWIDTH-1:0]     RetireTag,
  output logic [TAGBITWIDTH:0]       TagsOutstanding,
  output logic                       CommitFullStall,
  output logic                       CommitError
);

  localparam int SLOTS = 1 << TAGBITWIDTH;
  localparam logic [TAGBITWIDTH:0] FULL_CNT = (TAGBITWIDTH+1)'(SLOTS);

  logic [TAGBITWIDTH-1:0] issue_ptr_q, issue_ptr_d;
  logic [TAGBITWIDTH-1:0] retire_ptr_q, retire_ptr_d;
  logic [TAGBITWIDTH:0]   outstanding_q, outstanding_d;
  logic                   error_q, error_d;

  // Completion ports gathered into index-addressable vectors.
  logic [NUM_PORTS-1:0]                      cmp_valid;
  logic [NUM_PORTS-1:0][TAGBITWIDTH-1:0]     cmp_tag;
  logic [NUM_PORTS-1:0]                      cmp_regwrite;
  logic [NUM_PORTS-1:0][REGADDRBITWIDTH-1:0] cmp_regaddr;
  logic [NUM_PORTS-1:0][DATABITWIDTH-1:0]    cmp_data;

  assign cmp_valid[PORT_ALU0]    = ALU0_Valid;
  assign cmp_tag[PORT_ALU0]      = ALU0_Tag;
  assign cmp_regwrite[PORT_ALU0] = ALU0_RegWriteEn;
  assign cmp_regaddr[PORT_ALU0]  = ALU0_RegAddr;
  assign cmp_data[PORT_ALU0]     = ALU0_Data;
  assign cmp_valid[PORT_ALU1]    = ALU1_Valid;
  assign cmp_tag[PORT_ALU1]      = ALU1_Tag;
  assign cmp_regwrite[PORT_ALU1] = ALU1_RegWriteEn;
  assign cmp_regaddr[PORT_ALU1]  = ALU1_RegAddr;
  assign cmp_data[PORT_ALU1]     = ALU1_Data;
  assign cmp_valid[PORT_MEM]     = Mem_Valid;
  assign cmp_tag[PORT_MEM]       = Mem_Tag;
  assign cmp_regwrite[PORT_MEM]  = Mem_RegWriteEn;
  assign cmp_regaddr[PORT_MEM]   = Mem_RegAddr;
  assign cmp_data[PORT_MEM]      = Mem_Data;

  logic [SLOTS-1:0]           slot_valid;
  logic                       head_valid;
  logic                       head_regwrite;
  logic [REGADDRBITWIDTH-1:0] head_regaddr;
  logic [DATABITWIDTH-1:0]    head_data;

  logic [NUM_PORTS-1:0] in_window;
  logic [NUM_PORTS-1:0] dup_hit;
  logic [NUM_PORTS-1:0] collide;
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] violate;

  logic full;
  logic issue;
  logic retire;

  // Window and duplicate screening per port. The window is measured as the
  // modular distance from the head, so pointer wrap needs no special case.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [TAGBITWIDTH-1:0] offset;
      assign offset        = cmp_tag[gi] - retire_ptr_q;
      assign in_window[gi] = {1'b0, offset} < outstanding_q;
      assign dup_hit[gi]   = slot_valid[cmp_tag[gi]];
    end
  endgenerate

  // Same-tag collisions: a port loses to any valid lower-index port.
  always_comb begin
    collide = '0;
    for (int p = 1; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (cmp_valid[q] && (cmp_tag[q] == cmp_tag[p])) collide[p] = 1'b1;
      end
    end
  end

  assign accept  = cmp_valid & in_window & ~dup_hit & ~collide;
  assign violate = cmp_valid & ~accept;

  assign full   = (outstanding_q == FULL_CNT);
  assign issue  = TagREQ & ~full;
  assign retire = head_valid & ((outstanding_q != '0) | TagREQ);

  commit_slot_array #(
    .DATA_W    (DATABITWIDTH),
    .REGADDR_W (REGADDRBITWIDTH),
    .TAG_W     (TAGBITWIDTH),
    .NUM_WR    (NUM_PORTS)
  ) u_slots (
    .clk           (clk),
    .clk_en_i      (clk_en),
    .sync_rst_i    (sync_rst),
    .wr_en_i       (accept),
    .wr_tag_i      (cmp_tag),
    .wr_regwrite_i (cmp_regwrite),
    .wr_regaddr_i  (cmp_regaddr),
    .wr_data_i     (cmp_data),
    .clr_en_i      (retire),
    .clr_tag_i     (retire_ptr_q),
    .rd_tag_i      (retire_ptr_q),
    .rd_valid_o    (head_valid),
    .rd_regwrite_o (head_regwrite),
    .rd_regaddr_o  (head_regaddr),
    .rd_data_o     (head_data),
    .valid_o       (slot_valid)
  );

  // Next state of pointers, outstanding count and the sticky error flag.
  always_comb begin
    issue_ptr_d   = issue_ptr_q + TAGBITWIDTH'(issue);
    retire_ptr_d  = retire_ptr_q + TAGBITWIDTH'(retire);
    outstanding_d = outstanding_q + (TAGBITWIDTH+1)'(issue) - (TAGBITWIDTH+1)'(retire);
    error_d       = error_q | (|violate) | (TagREQ & full);
  end

  // Control state register; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      issue_ptr_q   <= '0;
      retire_ptr_q  <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else if (clk_en) begin
      issue_ptr_q   <= issue_ptr_d;
      retire_ptr_q  <= retire_ptr_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  // issue_ptr_q tracks the window end; the window itself is derived from
  // the count, so the pointer only feeds itself.
  logic unused_issue_ptr;
  assign unused_issue_ptr = ^issue_ptr_q;

  assign Write_En        = head_valid & head_regwrite;
  assign Write_Address   = head_valid ? head_regaddr : '0;
  assign Write_Data      = head_valid ? head_data : '0;
  assign Forward1Valid   = Write_En;
  assign Forward1RegAddr = Write_Address;
  assign Forward1Data    = Write_Data;
  assign RetireTag       = retire_ptr_q;
  assign TagsOutstanding = outstanding_q;
  assign CommitFullStall = full;
  assign CommitError     = error_q;

endmodule

// File: tb/tb_writeback_commit.sv
// Directed bench for writeback_commit with a write scoreboard.
module tb_writeback_commit;

  logic        clk = 1'b0;
  logic        clk_en, sync_rst, TagREQ;
  logic        ALU0_Valid, ALU0_RegWriteEn, ALU1_Valid, ALU1_RegWriteEn, Mem_Valid, Mem_RegWriteEn;
  logic [5:0]  ALU0_Tag, ALU1_Tag, Mem_Tag;
  logic [3:0]  ALU0_RegAddr, ALU1_RegAddr, Mem_RegAddr;
  logic [15:0] ALU0_Data, ALU1_Data, Mem_Data;
  logic        Write_En, Forward1Valid, CommitFullStall, CommitError;
  logic [3:0]  Write_Address, Forward1RegAddr;
  logic [15:0] Write_Data, Forward1Data;
  logic [5:0]  RetireTag;
  logic [6:0]  TagsOutstanding;

  int assert_count = 0;
  int fail_count   = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  writeback_commit dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .TagREQ(TagREQ),
    .ALU0_Valid(ALU0_Valid), .ALU0_Tag(ALU0_Tag), .ALU0_RegWriteEn(ALU0_RegWriteEn),
    .ALU0_RegAddr(ALU0_RegAddr), .ALU0_Data(ALU0_Data),
    .ALU1_Valid(ALU1_Valid), .ALU1_Tag(ALU1_Tag), .ALU1_RegWriteEn(ALU1_RegWriteEn),
    .ALU1_RegAddr(ALU1_RegAddr), .ALU1_Data(ALU1_Data),
    .Mem_Valid(Mem_Valid), .Mem_Tag(Mem_Tag), .Mem_RegWriteEn(Mem_RegWriteEn),
    .Mem_RegAddr(Mem_RegAddr), .Mem_Data(Mem_Data),
    .Write_En(Write_En), .Write_Address(Write_Address), .Write_Data(Write_Data),
    .Forward1Valid(Forward1Valid), .Forward1RegAddr(Forward1RegAddr), .Forward1Data(Forward1Data),
    .RetireTag(RetireTag), .TagsOutstanding(TagsOutstanding),
    .CommitFullStall(CommitFullStall), .CommitError(CommitError)
  );

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    TagREQ = 1'b0;
    ALU0_Valid = 1'b0; ALU0_Tag = '0; ALU0_RegWriteEn = 1'b0; ALU0_RegAddr = '0; ALU0_Data = '0;
    ALU1_Valid = 1'b0; ALU1_Tag = '0; ALU1_RegWriteEn = 1'b0; ALU1_RegAddr = '0; ALU1_Data = '0;
    Mem_Valid  = 1'b0; Mem_Tag  = '0; Mem_RegWriteEn  = 1'b0; Mem_RegAddr  = '0; Mem_Data  = '0;
  endtask

  task automatic drive_port(input int p, input logic [5:0] tag, input logic rw,
                            input logic [3:0] addr, input logic [15:0] data);
    case (p)
      0: begin ALU0_Valid = 1'b1; ALU0_Tag = tag; ALU0_RegWriteEn = rw; ALU0_RegAddr = addr; ALU0_Data = data; end
      1: begin ALU1_Valid = 1'b1; ALU1_Tag = tag; ALU1_RegWriteEn = rw; ALU1_RegAddr = addr; ALU1_Data = data; end
      default: begin Mem_Valid = 1'b1; Mem_Tag = tag; Mem_RegWriteEn = rw; Mem_RegAddr = addr; Mem_Data = data; end
    endcase
  endtask

  task automatic do_reset();
    idle_ports();
    clk_en = 1'b1;
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
  endtask

  task automatic issue_tags(input int n);
    TagREQ = 1'b1;
    repeat (n) step();
    TagREQ = 1'b0;
  endtask

  // Every committed register-file write must match the next expected entry.
  always @(negedge clk) begin
    if (clk_en && !sync_rst && Write_En) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_write", {28'd0, Write_Address}, 32'hFFFF_FFFF);
      end else begin
        automatic logic [19:0] e = exp_q.pop_front();
        check_value("write_addr", Write_Address, e[19:16]);
        check_value("write_data", Write_Data, e[15:0]);
        check_value("fwd_valid", Forward1Valid, 1);
        check_value("fwd_addr", Forward1RegAddr, e[19:16]);
        check_value("fwd_data", Forward1Data, e[15:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    check_value("rst_write_en", Write_En, 0);
    check_value("rst_retire_tag", RetireTag, 0);
    check_value("rst_outstanding", TagsOutstanding, 0);
    check_value("rst_stall", CommitFullStall, 0);
    check_value("rst_error", CommitError, 0);

    // In-order retire.
    issue_tags(3);
    check_value("io_outstanding3", TagsOutstanding, 3);
    drive_port(0, 6'd0, 1'b1, 4'd3, 16'h1234);
    exp_q.push_back({4'd3, 16'h1234});
    step();
    idle_ports();
    check_value("io_latency_we", Write_En, 1);
    drive_port(1, 6'd1, 1'b1, 4'd5, 16'h00FF);
    exp_q.push_back({4'd5, 16'h00FF});
    step();
    idle_ports();
    check_value("io_outstanding2", TagsOutstanding, 2);
    check_value("io_second_we", Write_En, 1);
    step();
    check_value("io_outstanding1", TagsOutstanding, 1);
    check_value("io_head2_idle", Write_En, 0);

    // Out-of-order completion.
    do_reset();
    issue_tags(3);
    drive_port(2, 6'd2, 1'b1, 4'd3, 16'h000C);
    step(); idle_ports();
    check_value("ooo_wait1", Write_En, 0);
    drive_port(0, 6'd1, 1'b1, 4'd2, 16'h000B);
    step(); idle_ports();
    check_value("ooo_wait2", Write_En, 0);
    drive_port(1, 6'd0, 1'b1, 4'd1, 16'h000A);
    exp_q.push_back({4'd1, 16'h000A});
    exp_q.push_back({4'd2, 16'h000B});
    exp_q.push_back({4'd3, 16'h000C});
    step(); idle_ports();
    step(); step(); step();
    check_value("ooo_outstanding", TagsOutstanding, 0);
    check_value("ooo_retire_tag", RetireTag, 3);

    // Silent retire.
    do_reset();
    issue_tags(2);
    drive_port(0, 6'd0, 1'b0, 4'd6, 16'h6666);
    drive_port(1, 6'd1, 1'b1, 4'd7, 16'h5555);
    exp_q.push_back({4'd7, 16'h5555});
    step(); idle_ports();
    check_value("silent_no_we", Write_En, 0);
    step();
    check_value("silent_next_we", Write_En, 1);
    check_value("silent_next_addr", Write_Address, 7);
    step();
    check_value("silent_retire_tag", RetireTag, 2);

    // Full and wrap.
    do_reset();
    issue_tags(64);
    check_value("full_outstanding", TagsOutstanding, 64);
    check_value("full_stall", CommitFullStall, 1);
    check_value("full_no_error", CommitError, 0);
    issue_tags(1);
    check_value("full_req_error", CommitError, 1);
    check_value("full_req_ignored", TagsOutstanding, 64);
    for (int i = 0; i < 64; i++) begin
      drive_port(0, 6'(i), 1'b1, 4'(i), 16'(i * 257));
      exp_q.push_back({4'(i), 16'(i * 257)});
      step(); idle_ports();
      if (i == 0) check_value("wrap_stall_held", CommitFullStall, 1);
      if (i == 1) check_value("wrap_stall_drop", CommitFullStall, 0);
    end
    step();
    check_value("wrap_outstanding", TagsOutstanding, 0);
    check_value("wrap_retire_tag", RetireTag, 0);
    check_value("wrap_error_sticky", CommitError, 1);

    // Duplicate completion.
    do_reset();
    issue_tags(5);
    drive_port(0, 6'd4, 1'b1, 4'd4, 16'h4444);
    exp_q.push_back({4'd4, 16'h4444});
    step(); idle_ports();
    check_value("dup_first_ok", CommitError, 0);
    drive_port(0, 6'd4, 1'b1, 4'd4, 16'hDEAD);
    step(); idle_ports();
    check_value("dup_error", CommitError, 1);
    drive_port(0, 6'd0, 1'b0, 4'd0, 16'h0);
    drive_port(1, 6'd1, 1'b0, 4'd0, 16'h0);
    drive_port(2, 6'd2, 1'b0, 4'd0, 16'h0);
    step(); idle_ports();
    drive_port(0, 6'd3, 1'b0, 4'd0, 16'h0);
    step(); idle_ports();
    repeat (5) step();
    check_value("dup_outstanding", TagsOutstanding, 0);
    check_value("dup_retire_tag", RetireTag, 5);

    // Same-tag collision: ALU0 wins.
    do_reset();
    issue_tags(2);
    drive_port(0, 6'd0, 1'b1, 4'd1, 16'h1111);
    drive_port(1, 6'd0, 1'b1, 4'd2, 16'h2222);
    drive_port(2, 6'd1, 1'b0, 4'd0, 16'h0);
    exp_q.push_back({4'd1, 16'h1111});
    step(); idle_ports();
    check_value("coll_error", CommitError, 1);
    step(); step();
    check_value("coll_outstanding", TagsOutstanding, 0);

    // Completion outside the outstanding window.
    do_reset();
    issue_tags(1);
    drive_port(2, 6'd3, 1'b1, 4'd2, 16'h3333);
    step(); idle_ports();
    check_value("oow_error", CommitError, 1);
    check_value("oow_outstanding", TagsOutstanding, 1);
    check_value("oow_no_we", Write_En, 0);

    // Clock enable hold, then reset with clk_en low.
    do_reset();
    issue_tags(2);
    drive_port(0, 6'd0, 1'b1, 4'd9, 16'h9999);
    drive_port(2, 6'd7, 1'b1, 4'd1, 16'h7777);
    exp_q.push_back({4'd9, 16'h9999});
    step(); idle_ports();
    check_value("ce_head_we", Write_En, 1);
    check_value("ce_pre_error", CommitError, 1);
    clk_en = 1'b0;
    TagREQ = 1'b1;
    drive_port(1, 6'd1, 1'b1, 4'd10, 16'hAAAA);
    repeat (3) step();
    check_value("ce_hold_tag", RetireTag, 0);
    check_value("ce_hold_count", TagsOutstanding, 2);
    check_value("ce_hold_addr", Write_Address, 9);
    idle_ports();
    clk_en = 1'b1;
    step();
    check_value("ce_resume_tag", RetireTag, 1);
    check_value("ce_resume_count", TagsOutstanding, 1);
    check_value("ce_no_capture", Write_En, 0);
    drive_port(1, 6'd1, 1'b1, 4'd10, 16'hAAAA);
    step(); idle_ports();
    check_value("mid_head_we", Write_En, 1);
    clk_en = 1'b0;
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    check_value("mrst_we", Write_En, 0);
    check_value("mrst_addr", Write_Address, 0);
    check_value("mrst_data", Write_Data, 0);
    check_value("mrst_fwd_valid", Forward1Valid, 0);
    check_value("mrst_fwd_addr", Forward1RegAddr, 0);
    check_value("mrst_fwd_data", Forward1Data, 0);
    check_value("mrst_retire_tag", RetireTag, 0);
    check_value("mrst_outstanding", TagsOutstanding, 0);
    check_value("mrst_stall", CommitFullStall, 0);
    check_value("mrst_error", CommitError, 0);
    clk_en = 1'b1;
    step();

    check_value("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
